// File: rtl/bbpd_pkg.sv
// Shared types and sizing helpers for the bang-bang phase-detector voter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bbpd_pkg;

    localparam int BBPD_DATA_W = 10;
    localparam int BBPD_DECIM  = 4;
    localparam int BBPD_THRESH = 2;
    localparam int BBPD_ACC_W  = 8;

    // Width needed to hold a popcount of n bits (0..n inclusive).
    function automatic int bbpd_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int BBPD_CNT_W = bbpd_cnt_w(BBPD_DATA_W);

    // Signed late-minus-early vote at the default accumulator width.
    typedef logic signed [BBPD_ACC_W-1:0] vote_t;
    // Per-word early/late popcount at the default word width.
    typedef logic [BBPD_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bbpd_word_classify.sv
// Classifies each data transition of one word as early or late and popcounts both.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, qualified by the caller.
module bbpd_word_classify
    import bbpd_pkg::*;
#(
    parameter int DATA_W = BBPD_DATA_W,
    parameter int CNT_W  = bbpd_cnt_w(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data_smp,
    input  logic [DATA_W-1:0] i_edge_smp,
    input  logic              i_prev_bit,
    input  logic              i_prev_valid,
    output logic [CNT_W-1:0]  o_late_cnt,
    output logic [CNT_W-1:0]  o_early_cnt
);

    logic [DATA_W-1:0] w_older;
    logic [DATA_W-1:0] w_active;
    logic [DATA_W-1:0] w_trans;
    logic [DATA_W-1:0] w_late;
    logic [DATA_W-1:0] w_early;

    // The bit received just before data bit i; bit 0 looks back into the previous word.
    assign w_older  = {i_data_smp[DATA_W-2:0], i_prev_bit};
    // Bit 0 has no trustworthy predecessor until a word has been seen since enable/reset.
    assign w_active = {{(DATA_W-1){1'b1}}, i_prev_valid};
    assign w_trans  = (w_older ^ i_data_smp) & w_active;
    // On a transition the edge sample matches exactly one side, so late/early are exclusive.
    assign w_late   = w_trans & ~(i_edge_smp ^ i_data_smp);
    assign w_early  = w_trans & ~(i_edge_smp ^ w_older);

    // Popcount the per-bit late and early flags.
    always_comb begin
        o_late_cnt  = '0;
        o_early_cnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            o_late_cnt  = o_late_cnt  + CNT_W'(w_late[i]);
            o_early_cnt = o_early_cnt + CNT_W'(w_early[i]);
        end
    end

endmodule

// File: rtl/bbpd_vote.sv
// Decimating Alexander phase-detector voter: nets late-minus-early over DECIM words, emits Up/Dn.
// Latency: word launched at edge N yields Up/Dn/vote_valid visible after edge N+2 (two register stages).
// Backpressure: none; every valid word is accepted, words are dropped while en is low.
module bbpd_vote
    import bbpd_pkg::*;
#(
    parameter int DATA_W = BBPD_DATA_W,
    parameter int DECIM  = BBPD_DECIM,
    parameter int THRESH = BBPD_THRESH,
    parameter int ACC_W  = BBPD_ACC_W,
    parameter int CNT_W  = bbpd_cnt_w(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        data_smp,
    input  logic [DATA_W-1:0]        edge_smp,
    output logic                     Up,
    output logic                     Dn,
    output logic                     vote_valid,
    output logic signed [ACC_W-1:0]  net_vote,
    output logic [ACC_W-1:0]         win_trans
);

    localparam int                       WCNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [WCNT_W-1:0]        WCNT_LAST = WCNT_W'(DECIM - 1);
    localparam logic signed [ACC_W-1:0]  THR_POS   = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0]  THR_NEG   = -THR_POS;

    // Parameter sanity: the accumulator must never wrap inside one window.
    if (DATA_W < 2) begin : g_chk_data_w
        $error("bbpd_vote: DATA_W must be at least 2");
    end
    if (DECIM < 1 || THRESH < 1) begin : g_chk_decim_thresh
        $error("bbpd_vote: DECIM and THRESH must be at least 1");
    end
    if (!((64'd1 << (ACC_W - 1)) > 64'(DATA_W * DECIM))) begin : g_chk_acc_w
        $error("bbpd_vote: ACC_W too narrow for DATA_W*DECIM");
    end
    if (CNT_W >= ACC_W) begin : g_chk_cnt_w
        $error("bbpd_vote: CNT_W must be narrower than ACC_W");
    end

    logic [CNT_W-1:0]         w_late_cnt;
    logic [CNT_W-1:0]         w_early_cnt;

    logic [CNT_W-1:0]         r_late_cnt;
    logic [CNT_W-1:0]         r_early_cnt;
    logic                     r_prev_bit;
    logic                     r_prev_valid;
    logic                     r_s1_valid;

    logic signed [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]         r_tacc;
    logic [WCNT_W-1:0]        r_wcnt;
    logic signed [ACC_W-1:0]  r_net_vote;
    logic [ACC_W-1:0]         r_win_trans;
    logic                     r_up;
    logic                     r_dn;
    logic                     r_vote_valid;

    logic [ACC_W-1:0]         w_late_ext;
    logic [ACC_W-1:0]         w_early_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]         w_tsum;
    logic                     w_last;

    bbpd_word_classify #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_classify (
        .i_data_smp   (data_smp),
        .i_edge_smp   (edge_smp),
        .i_prev_bit   (r_prev_bit),
        .i_prev_valid (r_prev_valid),
        .o_late_cnt   (w_late_cnt),
        .o_early_cnt  (w_early_cnt)
    );

    // Stage 1: capture per-word counts and remember the last bit for the next word's bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_late_cnt   <= '0;
            r_early_cnt  <= '0;
            r_prev_bit   <= 1'b0;
            r_prev_valid <= 1'b0;
            r_s1_valid   <= 1'b0;
        end else if (!en) begin
            r_prev_valid <= 1'b0;
            r_s1_valid   <= 1'b0;
        end else begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
                r_late_cnt   <= w_late_cnt;
                r_early_cnt  <= w_early_cnt;
                r_prev_bit   <= data_smp[DATA_W-1];
                r_prev_valid <= 1'b1;
            end
        end
    end

    assign w_late_ext  = {{(ACC_W-CNT_W){1'b0}}, r_late_cnt};
    assign w_early_ext = {{(ACC_W-CNT_W){1'b0}}, r_early_cnt};
    // Running totals including the word currently in stage 1; used both to accumulate and to close.
    assign w_sum       = r_acc + $signed(w_late_ext) - $signed(w_early_ext);
    assign w_tsum      = r_tacc + w_late_ext + w_early_ext;
    assign w_last      = (r_wcnt == WCNT_LAST);

    // Stage 2: accumulate over the window, and on the closing word publish totals and decide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_tacc       <= '0;
            r_wcnt       <= '0;
            r_net_vote   <= '0;
            r_win_trans  <= '0;
            r_up         <= 1'b0;
            r_dn         <= 1'b0;
            r_vote_valid <= 1'b0;
        end else if (!en) begin
            r_acc        <= '0;
            r_tacc       <= '0;
            r_wcnt       <= '0;
            r_up         <= 1'b0;
            r_dn         <= 1'b0;
            r_vote_valid <= 1'b0;
        end else begin
            r_up         <= 1'b0;
            r_dn         <= 1'b0;
            r_vote_valid <= 1'b0;
            if (r_s1_valid) begin
                if (w_last) begin
                    r_net_vote   <= w_sum;
                    r_win_trans  <= w_tsum;
                    r_vote_valid <= 1'b1;
                    r_up         <= (w_sum >= THR_POS);
                    r_dn         <= (w_sum <= THR_NEG);
                    r_acc        <= '0;
                    r_tacc       <= '0;
                    r_wcnt       <= '0;
                end else begin
                    r_acc        <= w_sum;
                    r_tacc       <= w_tsum;
                    r_wcnt       <= r_wcnt + WCNT_W'(1);
                end
            end
        end
    end

    assign Up         = r_up;
    assign Dn         = r_dn;
    assign vote_valid = r_vote_valid;
    assign net_vote   = r_net_vote;
    assign win_trans  = r_win_trans;

endmodule

// File: tb/tb_bbpd_vote.sv
// Directed self-checking bench for bbpd_vote with hand-computed window totals.
// Latency: words are launched #1 after an edge; the decision is expected after the second following edge.
// Backpressure: none exercised; the voter always accepts.
module tb_bbpd_vote;
    import bbpd_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        valid_in = 1'b0;
    logic [9:0]  data_smp = '0;
    logic [9:0]  edge_smp = '0;
    logic        Up;
    logic        Dn;
    logic        vote_valid;
    logic [7:0]  net_vote;
    logic [7:0]  win_trans;

    int          n_checks = 0;
    int          n_fail = 0;

    int          stray;
    logic [2:0]  pre, pulse, post;
    logic [7:0]  nv, tr;

    always #5 clk = ~clk;

    bbpd_vote #(
        .DATA_W (10),
        .DECIM  (4),
        .THRESH (2),
        .ACC_W  (8),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .valid_in   (valid_in),
        .data_smp   (data_smp),
        .edge_smp   (edge_smp),
        .Up         (Up),
        .Dn         (Dn),
        .vote_valid (vote_valid),
        .net_vote   (net_vote),
        .win_trans  (win_trans)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        valid_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Drives four valid words (d[0] first) with optional idle gaps, and reports what the outputs did.
    task automatic run_window(input logic [3:0][9:0] d, input logic [3:0][9:0] e, input int gap,
                              output int st, output logic [2:0] pr, output logic [2:0] pu,
                              output logic [2:0] po, output logic [7:0] n, output logic [7:0] t);
        st = 0;
        for (int w = 0; w < 4; w++) begin
            valid_in = 1'b1;
            data_smp = d[w];
            edge_smp = e[w];
            tick();
            valid_in = 1'b0;
            data_smp = 10'($urandom);
            edge_smp = 10'($urandom);
            if (w < 3) begin
                if (Up | Dn | vote_valid) st++;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (Up | Dn | vote_valid) st++;
                end
            end
        end
        pr = {Up, Dn, vote_valid};
        tick();
        pu = {Up, Dn, vote_valid};
        n  = net_vote;
        t  = win_trans;
        tick();
        po = {Up, Dn, vote_valid};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            data_smp = 10'($urandom);
            edge_smp = 10'($urandom);
            tick();
        end
        n_checks++;
        if ({Up, Dn, vote_valid, net_vote, win_trans} !== 19'd0)
            begin n_fail++; $display("FAIL reset_hold: outs=%h expected 0", {Up, Dn, vote_valid, net_vote, win_trans}); end
        en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_smp = 10'($urandom);
            edge_smp = 10'($urandom);
            tick();
        end
        valid_in = 1'b0;
        n_checks++;
        if ({Up, Dn, vote_valid, net_vote, win_trans} !== 19'd0)
            begin n_fail++; $display("FAIL reset_en_low: outs=%h expected 0", {Up, Dn, vote_valid, net_vote, win_trans}); end
    endtask

    task automatic test_late();
        logic [9:0] p;
        logic [3:0][9:0] d;
        p = 10'b0101010101;
        d = {p, p, p, p};
        do_reset();
        en = 1'b1;
        run_window(d, d, 0, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b101) begin n_fail++; $display("FAIL late_w1_pulse: UpDnVv=%b expected 101", pulse); end
        n_checks++; if (nv !== vote_t'(39)) begin n_fail++; $display("FAIL late_w1_net: %0d expected 39", $signed(nv)); end
        n_checks++; if (tr !== 8'd39) begin n_fail++; $display("FAIL late_w1_trans: %0d expected 39", tr); end
        n_checks++; if ({pre, post} !== 6'd0) begin n_fail++; $display("FAIL late_w1_edges: pre=%b post=%b expected 0", pre, post); end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL late_w1_stray: %0d expected 0", stray); end
        run_window(d, d, 0, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b101) begin n_fail++; $display("FAIL late_w2_pulse: UpDnVv=%b expected 101", pulse); end
        n_checks++; if (nv !== vote_t'(40)) begin n_fail++; $display("FAIL late_w2_net: %0d expected 40", $signed(nv)); end
        n_checks++; if (tr !== 8'd40) begin n_fail++; $display("FAIL late_w2_trans: %0d expected 40", tr); end
        n_checks++; if ({pre, post, 5'(stray)} !== 11'd0) begin n_fail++; $display("FAIL late_w2_edges: pre=%b post=%b stray=%0d expected 0", pre, post, stray); end
    endtask

    task automatic test_early();
        logic [9:0] p, q;
        logic [3:0][9:0] d, e;
        p = 10'b0101010101;
        q = {p[8:0], 1'b0};
        d = {p, p, p, p};
        e = {q, q, q, q};
        do_reset();
        en = 1'b1;
        run_window(d, e, 0, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b011) begin n_fail++; $display("FAIL early_w1_pulse: UpDnVv=%b expected 011", pulse); end
        n_checks++; if (nv !== vote_t'(-39)) begin n_fail++; $display("FAIL early_w1_net: %0d expected -39", $signed(nv)); end
        n_checks++; if (tr !== 8'd39) begin n_fail++; $display("FAIL early_w1_trans: %0d expected 39", tr); end
        n_checks++; if ({pre, post, 5'(stray)} !== 11'd0) begin n_fail++; $display("FAIL early_w1_edges: pre=%b post=%b stray=%0d expected 0", pre, post, stray); end
        run_window(d, e, 0, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b011) begin n_fail++; $display("FAIL early_w2_pulse: UpDnVv=%b expected 011", pulse); end
        n_checks++; if (nv !== vote_t'(-40)) begin n_fail++; $display("FAIL early_w2_net: %0d expected -40", $signed(nv)); end
        n_checks++; if (tr !== 8'd40) begin n_fail++; $display("FAIL early_w2_trans: %0d expected 40", tr); end
    endtask

    task automatic test_threshold();
        logic [3:0][9:0] d, e;
        // +2: rising edge at bit 1 and falling edge at bit 3, both sampled late.
        d = '0; d[0] = 10'b0000000110; e = d;
        do_reset(); en = 1'b1;
        run_window(d, e, 0, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b101) begin n_fail++; $display("FAIL thr_p2_pulse: UpDnVv=%b expected 101", pulse); end
        n_checks++; if ({nv, tr} !== {vote_t'(2), 8'd2}) begin n_fail++; $display("FAIL thr_p2_totals: net=%0d trans=%0d expected 2/2", $signed(nv), tr); end
        // +1: single late transition at bit 7, remaining words all ones (no transitions).
        d = {10'h3FF, 10'h3FF, 10'h3FF, 10'b1110000000}; e = d;
        do_reset(); en = 1'b1;
        run_window(d, e, 0, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b001) begin n_fail++; $display("FAIL thr_p1_pulse: UpDnVv=%b expected 001", pulse); end
        n_checks++; if ({nv, tr} !== {vote_t'(1), 8'd1}) begin n_fail++; $display("FAIL thr_p1_totals: net=%0d trans=%0d expected 1/1", $signed(nv), tr); end
        // -2: same two transitions, edge samples equal the older bit.
        d = '0; d[0] = 10'b0000000110; e = '0; e[0] = 10'b0000001000;
        do_reset(); en = 1'b1;
        run_window(d, e, 0, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b011) begin n_fail++; $display("FAIL thr_m2_pulse: UpDnVv=%b expected 011", pulse); end
        n_checks++; if ({nv, tr} !== {vote_t'(-2), 8'd2}) begin n_fail++; $display("FAIL thr_m2_totals: net=%0d trans=%0d expected -2/2", $signed(nv), tr); end
    endtask

    task automatic test_zero_gaps();
        logic [3:0][9:0] d;
        d = '0;
        do_reset(); en = 1'b1;
        // Seed net_vote/win_trans with a non-zero window so the zero result is a real update.
        run_window({4{10'b0101010101}}, {4{10'b0101010101}}, 0, stray, pre, pulse, post, nv, tr);
        run_window(d, d, 3, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b001) begin n_fail++; $display("FAIL zero_pulse: UpDnVv=%b expected 001", pulse); end
        n_checks++; if ({nv, tr} !== 16'd0) begin n_fail++; $display("FAIL zero_totals: net=%0d trans=%0d expected 0/0", $signed(nv), tr); end
        n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL zero_gap_stray: %0d expected 0", stray); end
        n_checks++; if ({pre, post} !== 6'd0) begin n_fail++; $display("FAIL zero_gap_edges: pre=%b post=%b expected 0", pre, post); end
    endtask

    task automatic test_en_drop();
        logic [9:0] p;
        int cnt;
        p = 10'b0101010101;
        do_reset(); en = 1'b1;
        run_window({4{p}}, {4{p}}, 0, stray, pre, pulse, post, nv, tr);
        valid_in = 1'b1; data_smp = p; edge_smp = p;
        tick();
        tick();
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Up | Dn | vote_valid) cnt++;
        end
        n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL endrop_pulses: %0d expected 0", cnt); end
        n_checks++; if ({net_vote, win_trans} !== {vote_t'(39), 8'd39}) begin n_fail++; $display("FAIL endrop_hold: net=%0d trans=%0d expected 39/39", $signed(net_vote), win_trans); end
        en = 1'b1;
        run_window({4{p}}, {4{p}}, 0, stray, pre, pulse, post, nv, tr);
        n_checks++; if (pulse !== 3'b101) begin n_fail++; $display("FAIL reen_pulse: UpDnVv=%b expected 101", pulse); end
        n_checks++; if (nv !== vote_t'(39)) begin n_fail++; $display("FAIL reen_net: %0d expected 39", $signed(nv)); end
        n_checks++; if ({pre, post, 5'(stray)} !== 11'd0) begin n_fail++; $display("FAIL reen_edges: pre=%b post=%b stray=%0d expected 0", pre, post, stray); end
    endtask

    task automatic test_async_reset();
        logic [9:0] p;
        int cnt;
        p = 10'b0101010101;
        do_reset(); en = 1'b1;
        run_window({4{p}}, {4{p}}, 0, stray, pre, pulse, post, nv, tr);
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_smp = p; edge_smp = p;
            tick();
        end
        valid_in = 1'b0;
        // Decision for this window is due at the next edge; reset lands before it.
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if ({Up, Dn, vote_valid, net_vote, win_trans} !== 19'd0) begin n_fail++; $display("FAIL arst_immediate: outs=%h expected 0", {Up, Dn, vote_valid, net_vote, win_trans}); end
        tick();
        n_checks++; if ({Up, Dn, vote_valid} !== 3'b000) begin n_fail++; $display("FAIL arst_lost_pulse: UpDnVv=%b expected 000", {Up, Dn, vote_valid}); end
        rst_n = 1'b1;
        valid_in = 1'b1; data_smp = p; edge_smp = p;
        tick();
        valid_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Up | Dn | vote_valid) cnt++;
        end
        n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL arst_fresh_window: pulses=%0d expected 0", cnt); end
        n_checks++; if ({net_vote, win_trans} !== 16'd0) begin n_fail++; $display("FAIL arst_totals: net=%0d trans=%0d expected 0/0", $signed(net_vote), win_trans); end
    endtask

    initial begin
        test_reset();
        test_late();
        test_early();
        test_threshold();
        test_zero_gaps();
        test_en_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
